// File: rtl/pipe_hazard_ctrl_if.sv
// Bus between the hazard/arbitration controller and the core datapath.
// The slave modport is the controller side; master is the datapath (or bench) side.
interface pipe_hazard_ctrl_if #(
  parameter int NSTAGE = 5,
  parameter int REGW   = 5
);
  // Memory handshake: imemREN/dmemREN/dmemWEN are requests held steady until the
  // matching ihit/dhit completes them; a request with its hit high in the same
  // cycle is a finished transfer, and a hit with no request is ignored.
  logic              ihit;
  logic              dhit;
  logic              memREN_ex;
  logic              memWEN_ex;
  logic              ld_idex;
  logic [REGW-1:0]   wsel_idex;
  logic [REGW-1:0]   rsel1_ifid;
  logic [REGW-1:0]   rsel2_ifid;
  logic              br_taken;
  logic              halt_wb;
  logic              imemREN;
  logic              dmemREN;
  logic              dmemWEN;
  logic [NSTAGE-2:0] lat_en;
  logic [NSTAGE-2:0] lat_flush;
  logic              halted;
  logic              err;
  logic [2:0]        state_dbg;

  modport master (
    output ihit, dhit, memREN_ex, memWEN_ex, ld_idex, wsel_idex,
           rsel1_ifid, rsel2_ifid, br_taken, halt_wb,
    input  imemREN, dmemREN, dmemWEN, lat_en, lat_flush, halted, err, state_dbg
  );

  modport slave (
    input  ihit, dhit, memREN_ex, memWEN_ex, ld_idex, wsel_idex,
           rsel1_ifid, rsel2_ifid, br_taken, halt_wb,
    output imemREN, dmemREN, dmemWEN, lat_en, lat_flush, halted, err, state_dbg
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard unit and single-port memory arbiter: drives per-latch
// enables/flushes, serialises fetch and data accesses, drains on halt.
module pipe_hazard_ctrl #(
  parameter int NSTAGE = 5,
  parameter int REGW   = 5,
  parameter int MEMSTG = 3,
  parameter int TOUT   = 64
) (
  input  logic             CLK,
  input  logic             RST,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int NL = NSTAGE - 1;
  localparam int TW = $clog2(TOUT + 1);
  localparam int DW = $clog2(NSTAGE);

  if (MEMSTG < 1 || MEMSTG > NL || TOUT < 2 || TOUT > 255 || NSTAGE < 3) begin : g_param_chk
    $error("pipe_hazard_ctrl: parameter out of range");
  end

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    DACC   = 3'd1,
    IWAIT  = 3'd2,
    DRAIN  = 3'd3,
    HALTED = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic [TW-1:0]   tcnt;
  logic [DW-1:0]   dcnt;
  logic            err_q;
  logic            waiting, hit, load_use;
  logic            imem, dren, dwen;
  logic [NL-1:0]   en, fl;

  assign load_use = bus.ld_idex && (bus.wsel_idex != '0) &&
                    ((bus.wsel_idex == bus.rsel1_ifid) || (bus.wsel_idex == bus.rsel2_ifid));
  assign waiting  = (state == DACC) || (state == IWAIT);
  assign hit      = (state == DACC) ? bus.dhit : bus.ihit;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= RUN;
      tcnt  <= '0;
      dcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (waiting && !hit) begin
        if (tcnt != TW'(TOUT)) tcnt <= tcnt + TW'(1);
        if (tcnt == TW'(TOUT - 1)) err_q <= 1'b1;
      end else begin
        tcnt <= '0;
      end
      if (state == DRAIN) dcnt <= dcnt + DW'(1);
      else                dcnt <= '0;
    end
  end

  always_comb begin
    state_nxt = state;
    imem      = 1'b0;
    dren      = 1'b0;
    dwen      = 1'b0;
    en        = '0;
    fl        = '0;
    case (state)
      RUN: begin
        imem = 1'b1;
        if (bus.halt_wb)                        state_nxt = DRAIN;
        else if (bus.memREN_ex || bus.memWEN_ex) state_nxt = DACC;
        else if (!bus.ihit)                     state_nxt = IWAIT;
        // Halt freezes the pipe with no flush, even against a taken branch.
        if (!bus.halt_wb && bus.ihit) begin
          en = '1;
          if (bus.br_taken) begin
            fl[0] = 1'b1;
            fl[1] = 1'b1;
          end else if (load_use) begin
            en[0] = 1'b0;
            fl[1] = 1'b1;
          end
        end
      end
      DACC: begin
        // Write wins so the memory never sees read and write together.
        dwen = bus.memWEN_ex;
        dren = bus.memREN_ex && !bus.memWEN_ex;
        if (bus.dhit) begin
          en        = '1;
          state_nxt = RUN;
        end
      end
      IWAIT: begin
        imem = 1'b1;
        if (bus.ihit) state_nxt = RUN;
      end
      DRAIN: begin
        if (dcnt == DW'(NSTAGE - 2)) state_nxt = HALTED;
      end
      HALTED: state_nxt = HALTED;
      default: state_nxt = RUN;
    endcase
    if (RST) begin
      imem = 1'b1;
      dren = 1'b0;
      dwen = 1'b0;
      en   = '0;
      fl   = '1;
    end
  end

  assign bus.imemREN   = imem;
  assign bus.dmemREN   = dren;
  assign bus.dmemWEN   = dwen;
  assign bus.lat_en    = en;
  assign bus.lat_flush = fl;
  assign bus.halted    = (state == HALTED) && !RST;
  assign bus.err       = err_q && !RST;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: RUN-state vector table plus
// hand-written sequences for memory waits, timeout, drain and reset.
module tb_pipe_hazard_ctrl;

  localparam int NSTAGE = 5;
  localparam int REGW   = 5;
  localparam logic [2:0] S_RUN = 3'd0, S_DACC = 3'd1, S_IWAIT = 3'd2,
                         S_DRAIN = 3'd3, S_HALTED = 3'd4;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  pipe_hazard_ctrl_if #(.NSTAGE(NSTAGE), .REGW(REGW)) bus ();

  pipe_hazard_ctrl #(.NSTAGE(NSTAGE), .REGW(REGW), .MEMSTG(3), .TOUT(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    bus.ihit = 1'b1; bus.dhit = 1'b0; bus.memREN_ex = 1'b0; bus.memWEN_ex = 1'b0;
    bus.ld_idex = 1'b0; bus.wsel_idex = '0; bus.rsel1_ifid = '0; bus.rsel2_ifid = '0;
    bus.br_taken = 1'b0; bus.halt_wb = 1'b0;
  endtask

  task automatic cyc();
    @(negedge CLK);
  endtask

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    exp_q.push_back(exp_v);
    n_cmp++;
    if (act !== exp_q.pop_front()) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic chk_out(input string name, input logic [3:0] en, input logic [3:0] fl,
                         input logic im, input logic dr, input logic dw);
    chk({name, ".lat_en"},    32'(bus.lat_en),    32'(en));
    chk({name, ".lat_flush"}, 32'(bus.lat_flush), 32'(fl));
    chk({name, ".imemREN"},   32'(bus.imemREN),   32'(im));
    chk({name, ".dmemREN"},   32'(bus.dmemREN),   32'(dr));
    chk({name, ".dmemWEN"},   32'(bus.dmemWEN),   32'(dw));
  endtask

  // ---------------- RUN-state vector table ----------------
  typedef struct {
    string      name;
    logic       ihit, ld;
    logic [4:0] wsel, rs1, rs2;
    logic       br, halt, mren, mwen;
    logic [3:0] en, fl;
    logic       im;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{"idle",        1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 4'hF, 4'h0, 1};
    vecs[1]  = '{"lu_rs2",      1, 1, 5'd8, 5'd1, 5'd8, 0, 0, 0, 0, 4'hE, 4'h2, 1};
    vecs[2]  = '{"lu_rs1",      1, 1, 5'd3, 5'd3, 5'd9, 0, 0, 0, 0, 4'hE, 4'h2, 1};
    vecs[3]  = '{"lu_r0",       1, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 4'hF, 4'h0, 1};
    vecs[4]  = '{"ld_nomatch",  1, 1, 5'd8, 5'd7, 5'd9, 0, 0, 0, 0, 4'hF, 4'h0, 1};
    vecs[5]  = '{"noload",      1, 0, 5'd8, 5'd8, 5'd8, 0, 0, 0, 0, 4'hF, 4'h0, 1};
    vecs[6]  = '{"br_lu",       1, 1, 5'd8, 5'd1, 5'd8, 1, 0, 0, 0, 4'hF, 4'h3, 1};
    vecs[7]  = '{"br",          1, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 4'hF, 4'h3, 1};
    vecs[8]  = '{"ifetch_miss", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 4'h0, 4'h0, 1};
    vecs[9]  = '{"halt_br",     1, 0, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0, 4'h0, 4'h0, 1};
    vecs[10] = '{"run_dreq",    1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 4'hF, 4'h0, 1};
    vecs[11] = '{"miss_br",     0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 4'h0, 4'h0, 1};
  end

  // ---------------- test sequence ----------------
  initial begin
    idle();
    RST = 1'b1;

    // Reset held two cycles, then release with a fetch completing.
    cyc(); #1;
    chk_out("rst1", 4'h0, 4'hF, 1'b1, 1'b0, 1'b0);
    cyc(); #1;
    chk_out("rst2", 4'h0, 4'hF, 1'b1, 1'b0, 1'b0);
    chk("rst.halted", 32'(bus.halted), 32'd0);
    chk("rst.err",    32'(bus.err),    32'd0);
    cyc(); RST = 1'b0; #1;
    chk("rel.state",  32'(bus.state_dbg), 32'(S_RUN));
    chk("rel.lat_en", 32'(bus.lat_en),    32'hF);

    // Table: inputs applied mid-cycle and withdrawn before the edge, so state stays RUN.
    for (int i = 0; i < 12; i++) begin
      cyc();
      bus.ihit = vecs[i].ihit; bus.ld_idex = vecs[i].ld; bus.wsel_idex = vecs[i].wsel;
      bus.rsel1_ifid = vecs[i].rs1; bus.rsel2_ifid = vecs[i].rs2; bus.br_taken = vecs[i].br;
      bus.halt_wb = vecs[i].halt; bus.memREN_ex = vecs[i].mren; bus.memWEN_ex = vecs[i].mwen;
      #1;
      chk_out(vecs[i].name, vecs[i].en, vecs[i].fl, vecs[i].im, 1'b0, 1'b0);
      #2;
      idle();
    end
    cyc(); #1;
    chk("tbl.state", 32'(bus.state_dbg), 32'(S_RUN));

    // Data read held off three cycles, completed on the fourth.
    bus.memREN_ex = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      chk("rd.state", 32'(bus.state_dbg), 32'(S_DACC));
      chk_out("rd.wait", 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
    end
    cyc(); bus.dhit = 1'b1; #1;
    chk("rd.hit.state", 32'(bus.state_dbg), 32'(S_DACC));
    chk_out("rd.hit", 4'hF, 4'h0, 1'b0, 1'b1, 1'b0);
    cyc(); idle(); #1;
    chk("rd.back.state", 32'(bus.state_dbg), 32'(S_RUN));
    chk("rd.err", 32'(bus.err), 32'd0);

    // Read and write requested together: write wins.
    bus.memREN_ex = 1'b1; bus.memWEN_ex = 1'b1;
    cyc(); #1;
    chk_out("rw.wait", 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    cyc(); bus.dhit = 1'b1; #1;
    chk_out("rw.hit", 4'hF, 4'h0, 1'b0, 1'b0, 1'b1);
    cyc(); idle(); #1;
    chk("rw.back.state", 32'(bus.state_dbg), 32'(S_RUN));

    // A data request during IWAIT waits for the next RUN cycle.
    bus.ihit = 1'b0;
    cyc(); bus.memREN_ex = 1'b1; #1;
    chk("iw.state", 32'(bus.state_dbg), 32'(S_IWAIT));
    chk_out("iw.req", 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    cyc(); bus.ihit = 1'b1; #1;
    chk("iw.hit.state", 32'(bus.state_dbg), 32'(S_IWAIT));
    chk("iw.hit.lat_en", 32'(bus.lat_en), 32'h0);
    cyc(); #1;
    chk("iw.run.state", 32'(bus.state_dbg), 32'(S_RUN));
    cyc(); bus.dhit = 1'b1; #1;
    chk("iw.dacc.state", 32'(bus.state_dbg), 32'(S_DACC));
    chk("iw.dacc.dmemREN", 32'(bus.dmemREN), 32'd1);
    cyc(); idle(); #1;
    chk("iw.back.state", 32'(bus.state_dbg), 32'(S_RUN));

    // Reset in the middle of a data access abandons it.
    bus.memREN_ex = 1'b1;
    cyc(); RST = 1'b1; #1;
    chk_out("rstd.now", 4'h0, 4'hF, 1'b1, 1'b0, 1'b0);
    cyc(); RST = 1'b0; idle(); #1;
    chk("rstd.state", 32'(bus.state_dbg), 32'(S_RUN));
    chk("rstd.lat_en", 32'(bus.lat_en), 32'hF);

    // Fetch timeout with TOUT=4: err after the fourth IWAIT cycle, sticky.
    bus.ihit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(); #1;
      chk("to.wait.state", 32'(bus.state_dbg), 32'(S_IWAIT));
      chk("to.wait.err",   32'(bus.err),       32'd0);
    end
    cyc(); #1;
    chk("to.err.state", 32'(bus.state_dbg), 32'(S_IWAIT));
    chk("to.err.set",   32'(bus.err),       32'd1);
    bus.ihit = 1'b1;
    cyc(); #1;
    chk("to.run.state", 32'(bus.state_dbg), 32'(S_RUN));
    chk("to.err.sticky", 32'(bus.err), 32'd1);

    // Halt drains for NSTAGE-1 cycles then sticks in HALTED.
    bus.halt_wb = 1'b1;
    cyc(); bus.halt_wb = 1'b0; #1;
    for (int i = 0; i < NSTAGE - 1; i++) begin
      chk("dr.state",  32'(bus.state_dbg), 32'(S_DRAIN));
      chk_out("dr.out", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
      chk("dr.halted", 32'(bus.halted), 32'd0);
      cyc(); #1;
    end
    bus.memREN_ex = 1'b1; bus.br_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("hl.halted", 32'(bus.halted), 32'd1);
      chk_out("hl.out", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
      cyc(); #1;
    end
    chk("hl.err", 32'(bus.err), 32'd1);

    // Only reset leaves HALTED.
    RST = 1'b1; idle();
    cyc(); RST = 1'b0; #1;
    chk("fin.state",  32'(bus.state_dbg), 32'(S_RUN));
    chk("fin.halted", 32'(bus.halted),    32'd0);
    chk("fin.err",    32'(bus.err),       32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
